// File: rtl/spin_monitor_if.sv
// Display-side bus of the spinner observer: segment/dp/clear in, decode and score out.
interface spin_monitor_if #(
  parameter int CNT_W = 8
);
  logic [6:0]       seg_i;
  logic             dp_i;
  logic             clear_i;
  logic [2:0]       pos_o;
  logic             pos_valid_o;
  logic             stopped_o;
  logic             err_o;
  logic [CNT_W-1:0] round_cnt_o;
  logic [CNT_W-1:0] win_cnt_o;

  modport master (
    output seg_i, dp_i, clear_i,
    input  pos_o, pos_valid_o, stopped_o, err_o, round_cnt_o, win_cnt_o
  );

  modport slave (
    input  seg_i, dp_i, clear_i,
    output pos_o, pos_valid_o, stopped_o, err_o, round_cnt_o, win_cnt_o
  );
endinterface

// File: rtl/spin_monitor.sv
// Decodes the spinner's 7-segment wheel back to a position, checks legal stepping,
// detects rest and keeps saturating round/win counts from the decimal point.
module spin_monitor #(
  parameter int SETTLE_CYCLES = 4096,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spin_monitor_if.slave  bus
);
  localparam int              SW   = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0]   SMAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {WAIT, SPIN, STOPPED} state_t;

  state_t           state_q, state_d;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             in_vld;
  logic [2:0]       pos_q, pos_d;
  logic             pos_vld_q, pos_vld_d;
  logic [SW-1:0]    stable_q, stable_d;
  logic             win_flag_q, win_flag_d;
  logic             win_hit_q, win_hit_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] win_q, win_d;

  logic             dec_ok;
  logic [2:0]       dec_pos;
  logic [2:0]       next_pos;

  // in_vld masks the reset value of seg_q so the first sampled pattern is not flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= '0;
      dp_q   <= 1'b0;
      in_vld <= 1'b0;
    end else begin
      seg_q  <= bus.seg_i;
      dp_q   <= bus.dp_i;
      in_vld <= 1'b1;
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_pos = 3'd0;
    case (seg_q)
      7'b1000000: dec_pos = 3'd0;
      7'b0100000: dec_pos = 3'd1;
      7'b0010000: dec_pos = 3'd2;
      7'b0001000: dec_pos = 3'd3;
      7'b0000100: dec_pos = 3'd4;
      7'b0000010: dec_pos = 3'd5;
      default:    dec_ok  = 1'b0;
    endcase
  end

  assign next_pos = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT;
      pos_q      <= '0;
      pos_vld_q  <= 1'b0;
      stable_q   <= '0;
      win_flag_q <= 1'b0;
      win_hit_q  <= 1'b0;
      err_q      <= 1'b0;
      round_q    <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      pos_vld_q  <= pos_vld_d;
      stable_q   <= stable_d;
      win_flag_q <= win_flag_d;
      win_hit_q  <= win_hit_d;
      err_q      <= err_d;
      round_q    <= round_d;
      win_q      <= win_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    pos_vld_d  = pos_vld_q;
    stable_d   = stable_q;
    win_flag_d = win_flag_q;
    win_hit_d  = 1'b0;
    err_d      = err_q;
    round_d    = round_q;
    win_d      = win_q;

    // a credited win lands one cycle after detection
    if (win_hit_q && win_q != CMAX) win_d = win_q + 1'b1;

    if (in_vld) begin
      if (!dec_ok) begin
        err_d     = 1'b1;
        pos_vld_d = 1'b0;
        stable_d  = '0;
        state_d   = WAIT;
      end else if (state_q == WAIT) begin
        pos_d     = dec_pos;
        pos_vld_d = 1'b1;
        stable_d  = '0;
        state_d   = SPIN;
      end else if (dec_pos != pos_q) begin
        if (dec_pos != next_pos) err_d = 1'b1;
        pos_d    = dec_pos;
        stable_d = '0;
        state_d  = SPIN;
      end else begin
        if (stable_q != SMAX) stable_d = stable_q + 1'b1;
        case (state_q)
          SPIN: if (stable_q == SMAX) begin
            state_d    = STOPPED;
            win_flag_d = 1'b0;
            if (round_q != CMAX) round_d = round_q + 1'b1;
          end
          STOPPED: if (dp_q && !win_flag_q) begin
            win_flag_d = 1'b1;
            win_hit_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (bus.clear_i) begin
      round_d = '0;
      win_d   = '0;
      err_d   = 1'b0;
    end
  end

  assign bus.pos_o       = pos_q;
  assign bus.pos_valid_o = pos_vld_q;
  assign bus.stopped_o   = (state_q == STOPPED);
  assign bus.err_o       = err_q;
  assign bus.round_cnt_o = round_q;
  assign bus.win_cnt_o   = win_q;
endmodule

// File: tb/tb_spin_monitor.sv
// Bench for spin_monitor: directed scenarios plus random segment traffic against a
// position/round/win model, on a wide-counter and a 2-bit-counter instance.
module tb_spin_monitor;
  localparam int S = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  spin_monitor_if #(.CNT_W(8)) m_if ();
  spin_monitor_if #(.CNT_W(2)) s_if ();
  assign s_if.seg_i   = m_if.seg_i;
  assign s_if.dp_i    = m_if.dp_i;
  assign s_if.clear_i = m_if.clear_i;

  spin_monitor #(.SETTLE_CYCLES(S), .CNT_W(8)) dut   (.clk(clk), .rst_n(rst_n), .bus(m_if));
  spin_monitor #(.SETTLE_CYCLES(S), .CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if));

  always #5 clk = ~clk;

  // model: mode 0=waiting for a valid pattern, 1=spinning, 2=at rest
  int         m_mode, m_pos, m_run, m_rounds, m_wins;
  bit         m_valid, m_err, m_cred, m_pend, m_have, m_dpq;
  logic [6:0] m_segq;

  function automatic int decode(logic [6:0] s);
    logic [6:0] one;
    for (int i = 0; i < 6; i++) begin
      one = 7'h40 >> i;
      if (s == one) return i;
    end
    return -1;
  endfunction

  function automatic int cap(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [6:0] pat_of(int p);
    logic [6:0] b;
    b = 7'h40;
    return b >> p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_run = 0; m_rounds = 0; m_wins = 0;
    m_valid = 0; m_err = 0; m_cred = 0; m_pend = 0; m_have = 0; m_dpq = 0; m_segq = '0;
  endtask

  task automatic model_edge(logic [6:0] seg, bit dp, bit clr);
    int p;
    if (m_pend) m_wins++;
    m_pend = 0;
    if (m_have) begin
      p = decode(m_segq);
      if (p < 0) begin
        m_err = 1; m_valid = 0; m_run = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        m_pos = p; m_valid = 1; m_run = 0; m_mode = 1;
      end else if (p != m_pos) begin
        if (p != (m_pos + 1) % 6) m_err = 1;
        m_pos = p; m_run = 0; m_mode = 1;
      end else begin
        if (m_mode == 1 && m_run == S - 1) begin
          m_mode = 2; m_rounds++; m_cred = 0;
        end else if (m_mode == 2 && m_dpq && !m_cred) begin
          m_cred = 1; m_pend = 1;
        end
        m_run = cap(m_run + 1, S - 1);
      end
    end
    if (clr) begin m_rounds = 0; m_wins = 0; m_err = 0; end
    m_segq = seg; m_dpq = dp; m_have = 1;
  endtask

  task automatic step();
    logic [6:0] s;
    bit d, c;
    s = m_if.seg_i; d = m_if.dp_i; c = m_if.clear_i;
    @(posedge clk);
    #1;
    model_edge(s, d, c);
  endtask

  task automatic test_reset();
    m_if.seg_i = 7'h40; m_if.dp_i = 1'b0; m_if.clear_i = 1'b0;
    rst_n = 1'b0;
    #22;
    tests++;
    if ({m_if.pos_o, m_if.pos_valid_o, m_if.stopped_o, m_if.err_o} !== 6'd0 ||
        m_if.round_cnt_o !== 8'd0 || m_if.win_cnt_o !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: pos=%0d vld=%0d stop=%0d err=%0d rnd=%0d win=%0d want all 0",
               m_if.pos_o, m_if.pos_valid_o, m_if.stopped_o, m_if.err_o, m_if.round_cnt_o, m_if.win_cnt_o);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_spin();
    logic [6:0] pats [7] = '{7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h40};
    int n, chg;
    for (int i = 0; i < 7; i++) begin
      m_if.seg_i = pats[i];
      if (i < 6) begin
        repeat (4) step();
        tests++;
        if (m_if.pos_o !== 3'(i % 6) || m_if.err_o !== 1'b0 || m_if.pos_valid_o !== 1'b1) begin
          fails++;
          $display("FAIL spin_pos[%0d]: pos=%0d err=%0d vld=%0d want pos=%0d err=0 vld=1",
                   i, m_if.pos_o, m_if.err_o, m_if.pos_valid_o, i % 6);
        end
      end
    end
    n = 0; chg = -1;
    while (n < 60 && m_if.stopped_o !== 1'b1) begin
      step(); n++;
      if (chg < 0 && m_if.pos_o === 3'd0) chg = n;
    end
    tests++;
    if (m_if.stopped_o !== 1'b1 || n - chg != S) begin
      fails++;
      $display("FAIL stop_latency: stopped=%0d after %0d cycles from change, want 1 after %0d",
               m_if.stopped_o, n - chg, S);
    end
    tests++;
    if (m_if.round_cnt_o !== 8'd1 || m_if.win_cnt_o !== 8'd0 || m_if.err_o !== 1'b0) begin
      fails++;
      $display("FAIL first_round: rnd=%0d win=%0d err=%0d want 1 0 0",
               m_if.round_cnt_o, m_if.win_cnt_o, m_if.err_o);
    end
  endtask

  task automatic test_win();
    m_if.dp_i = 1'b1; step();
    m_if.dp_i = 1'b0; step();
    tests++;
    if (m_if.win_cnt_o !== 8'd0) begin
      fails++; $display("FAIL win_early: win=%0d want 0 one edge after dp_q", m_if.win_cnt_o);
    end
    step();
    tests++;
    if (m_if.win_cnt_o !== 8'd1) begin
      fails++; $display("FAIL win_latency: win=%0d want 1 at K+2", m_if.win_cnt_o);
    end
    repeat (2) begin
      m_if.dp_i = 1'b1; step();
      m_if.dp_i = 1'b0; repeat (3) step();
    end
    tests++;
    if (m_if.win_cnt_o !== 8'd1 || m_if.win_cnt_o !== 8'(m_wins)) begin
      fails++; $display("FAIL win_once: win=%0d want 1 (model %0d)", m_if.win_cnt_o, m_wins);
    end
    m_if.dp_i = 1'b1; m_if.seg_i = 7'h20;
    repeat (S + 6) step();
    tests++;
    if (m_if.round_cnt_o !== 8'd2 || m_if.win_cnt_o !== 8'd2 || m_if.stopped_o !== 1'b1) begin
      fails++;
      $display("FAIL second_round: rnd=%0d win=%0d stop=%0d want 2 2 1",
               m_if.round_cnt_o, m_if.win_cnt_o, m_if.stopped_o);
    end
    m_if.dp_i = 1'b0;
  endtask

  task automatic test_step_err();
    m_if.seg_i = 7'h20; repeat (2) step();
    m_if.seg_i = 7'h08; repeat (2) step();
    tests++;
    if (m_if.err_o !== 1'b1 || m_if.pos_o !== 3'd3) begin
      fails++; $display("FAIL illegal_step: err=%0d pos=%0d want 1 3", m_if.err_o, m_if.pos_o);
    end
    repeat (3) step();
    tests++;
    if (m_if.err_o !== 1'b1) begin
      fails++; $display("FAIL err_sticky: err=%0d want 1", m_if.err_o);
    end
    m_if.clear_i = 1'b1; step(); m_if.clear_i = 1'b0;
    tests++;
    if (m_if.err_o !== 1'b0 || m_if.round_cnt_o !== 8'd0 || m_if.win_cnt_o !== 8'd0) begin
      fails++;
      $display("FAIL clear: err=%0d rnd=%0d win=%0d want 0 0 0",
               m_if.err_o, m_if.round_cnt_o, m_if.win_cnt_o);
    end
  endtask

  task automatic test_invalid();
    logic [6:0] bad [3] = '{7'h01, 7'h00, 7'h60};
    for (int i = 0; i < 3; i++) begin
      m_if.seg_i = bad[i]; repeat (2) step();
      tests++;
      if (m_if.err_o !== 1'b1 || m_if.pos_valid_o !== 1'b0 || m_if.stopped_o !== 1'b0) begin
        fails++;
        $display("FAIL invalid[%0h]: err=%0d vld=%0d stop=%0d want 1 0 0",
                 bad[i], m_if.err_o, m_if.pos_valid_o, m_if.stopped_o);
      end
      m_if.seg_i = 7'h08; m_if.clear_i = 1'b1; step();
      m_if.clear_i = 1'b0; step();
      tests++;
      if (m_if.pos_o !== 3'd3 || m_if.pos_valid_o !== 1'b1 || m_if.err_o !== 1'b0) begin
        fails++;
        $display("FAIL reacquire[%0h]: pos=%0d vld=%0d err=%0d want 3 1 0",
                 bad[i], m_if.pos_o, m_if.pos_valid_o, m_if.err_o);
      end
    end
  endtask

  task automatic test_sat();
    int n;
    m_if.clear_i = 1'b1; step(); m_if.clear_i = 1'b0;
    m_if.dp_i = 1'b1;
    for (int r = 0; r < 5; r++) begin
      m_if.seg_i = pat_of((m_pos + 1) % 6);
      repeat (S + 6) step();
    end
    tests++;
    if (s_if.round_cnt_o !== 2'd3 || s_if.win_cnt_o !== 2'd3 ||
        m_if.round_cnt_o !== 8'd5 || m_if.win_cnt_o !== 8'd5) begin
      fails++;
      $display("FAIL saturate: small rnd=%0d win=%0d want 3 3, wide rnd=%0d win=%0d want 5 5",
               s_if.round_cnt_o, s_if.win_cnt_o, m_if.round_cnt_o, m_if.win_cnt_o);
    end
    m_if.dp_i = 1'b0;
    m_if.seg_i = pat_of((m_pos + 1) % 6);
    n = 0;
    step();
    while (n < 60 && !(m_mode == 1 && m_run == S - 1 && decode(m_segq) == m_pos)) begin
      step(); n++;
    end
    tests++;
    if (n >= 60 || s_if.stopped_o !== 1'b0 || s_if.round_cnt_o !== 2'd3) begin
      fails++;
      $display("FAIL pre_stop: waited=%0d stop=%0d rnd=%0d want <60 0 3", n, s_if.stopped_o, s_if.round_cnt_o);
    end
    m_if.clear_i = 1'b1; step(); m_if.clear_i = 1'b0;
    tests++;
    if (s_if.stopped_o !== 1'b1 || s_if.round_cnt_o !== 2'd0 || s_if.win_cnt_o !== 2'd0 ||
        m_if.round_cnt_o !== 8'd0) begin
      fails++;
      $display("FAIL clear_collision: stop=%0d rnd=%0d win=%0d wide rnd=%0d want 1 0 0 0",
               s_if.stopped_o, s_if.round_cnt_o, s_if.win_cnt_o, m_if.round_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    m_if.seg_i = pat_of((m_pos + 1) % 6);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({m_if.pos_o, m_if.pos_valid_o, m_if.stopped_o, m_if.err_o} !== 6'd0 ||
        m_if.round_cnt_o !== 8'd0 || s_if.win_cnt_o !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: pos=%0d vld=%0d stop=%0d err=%0d rnd=%0d want all 0",
               m_if.pos_o, m_if.pos_valid_o, m_if.stopped_o, m_if.err_o, m_if.round_cnt_o);
    end
    model_reset();
    m_if.seg_i = 7'h10;
    #2 rst_n = 1'b1;
    repeat (2) step();
    tests++;
    if (m_if.pos_o !== 3'd2 || m_if.pos_valid_o !== 1'b1 || m_if.err_o !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_acquire: pos=%0d vld=%0d err=%0d want 2 1 0",
               m_if.pos_o, m_if.pos_valid_o, m_if.err_o);
    end
  endtask

  task automatic test_random();
    int r, hold;
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      m_if.seg_i = pat_of(m_valid ? (m_pos + 1) % 6 : $urandom_range(0, 5));
      else if (r < 8) m_if.seg_i = pat_of($urandom_range(0, 5));
      else            m_if.seg_i = 7'($urandom_range(0, 127));
      m_if.dp_i = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 22);
      for (int h = 0; h < hold; h++) begin
        m_if.clear_i = ($urandom_range(0, 39) == 0);
        step();
        tests++;
        if (m_if.pos_o !== 3'(m_pos) || m_if.pos_valid_o !== m_valid ||
            m_if.stopped_o !== (m_mode == 2) || m_if.err_o !== m_err ||
            m_if.round_cnt_o !== 8'(cap(m_rounds, 255)) || m_if.win_cnt_o !== 8'(cap(m_wins, 255)) ||
            s_if.round_cnt_o !== 2'(cap(m_rounds, 3)) || s_if.win_cnt_o !== 2'(cap(m_wins, 3))) begin
          fails++;
          $display("FAIL random[%0d.%0d]: pos=%0d/%0d vld=%0d/%0d stop=%0d/%0d err=%0d/%0d rnd=%0d/%0d win=%0d/%0d srnd=%0d swin=%0d (got/want)",
                   seg, h, m_if.pos_o, m_pos, m_if.pos_valid_o, m_valid, m_if.stopped_o, m_mode == 2,
                   m_if.err_o, m_err, m_if.round_cnt_o, cap(m_rounds, 255), m_if.win_cnt_o,
                   cap(m_wins, 255), s_if.round_cnt_o, s_if.win_cnt_o);
        end
      end
    end
    m_if.clear_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spin();
    test_win();
    test_step_err();
    test_invalid();
    test_sat();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
